// File: rtl/axi4_lite_slave_regfile_pkg.sv
// Shared types and constants for the AXI4-Lite register-file responder.
// Response codes, FSM state encodings and the byte-strobe merge helper.
package axi4_lite_slave_regfile_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    // Byte lanes with a set strobe take the new data, the rest keep the old value.
    function automatic logic [DATA_WIDTH-1:0] apply_strb(
        input logic [DATA_WIDTH-1:0] old_val,
        input logic [DATA_WIDTH-1:0] new_val,
        input logic [STRB_WIDTH-1:0] strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_val;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi4_lite_slave_regfile_addr_decode.sv
// Combinational address decode: flags whether a byte address falls inside the
// register bank and yields the word index; the low two address bits are ignored.
module axi4_lite_addr_decode
    import axi4_lite_slave_regfile_pkg::*;
#(
    parameter int          NUM_REGS   = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0]       addr,
    output logic                        in_range,
    output logic [$clog2(NUM_REGS)-1:0] index
);

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   SPAN = (ADDR_WIDTH + 1)'(NUM_REGS * 4);

    logic [ADDR_WIDTH-1:0] offset;

    assign offset   = addr - BASE;
    assign in_range = (addr >= BASE) && ({1'b0, offset} < SPAN);
    assign index    = offset[$clog2(NUM_REGS)+1:2];

endmodule

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite responder holding NUM_REGS 32-bit registers with independent read and
// write paths. Define AXI4_LITE_REGFILE_PROT_EN to reject unprivileged accesses.
module axi4_lite_slave_regfile
    import axi4_lite_slave_regfile_pkg::*;
#(
    parameter int          NUM_REGS   = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [2:0]            awprot,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [2:0]            arprot,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [31:0]           rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready
);

    localparam int IDX_W = $clog2(NUM_REGS);

    // Handshakes: a beat transfers on a rising edge where valid && ready are both high.
    // Sources hold valid and payload until the transfer; all outputs here are registered.

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    wr_state_e             wr_state, wr_state_n;
    logic                  aw_held, aw_held_n;
    logic                  w_held, w_held_n;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic                  awready_n, wready_n, bvalid_n;
    logic [1:0]            bresp_n;
    logic                  reg_we;

    rd_state_e             rd_state, rd_state_n;
    logic                  arready_n, rvalid_n;
    logic [1:0]            rresp_n;
    logic [DATA_WIDTH-1:0] rdata_n;

    logic                  aw_hs, w_hs, ar_hs;
    logic                  wr_in_range, rd_in_range;
    logic                  wr_ok, rd_ok;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic                  unused_prot;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign ar_hs = arvalid && arready;

    axi4_lite_addr_decode #(
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE_ADDR),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_wr_decode (
        .addr    (awaddr_q),
        .in_range(wr_in_range),
        .index   (wr_idx)
    );

    axi4_lite_addr_decode #(
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE_ADDR),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_rd_decode (
        .addr    (araddr),
        .in_range(rd_in_range),
        .index   (rd_idx)
    );

`ifdef AXI4_LITE_REGFILE_PROT_EN
    logic awpriv_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) awpriv_q <= 1'b0;
        else if (aw_hs) awpriv_q <= awprot[0];
    end

    assign wr_ok       = wr_in_range && awpriv_q;
    assign rd_ok       = rd_in_range && arprot[0];
    assign unused_prot = ^{awprot[2:1], arprot[2:1]};
`else
    assign wr_ok       = wr_in_range;
    assign rd_ok       = rd_in_range;
    assign unused_prot = ^{awprot, arprot};
`endif

    // Write path: AW and W are latched independently; the commit fires on the
    // edge after both are held, so the readies stay low until bready.
    always_comb begin
        wr_state_n = wr_state;
        aw_held_n  = aw_held;
        w_held_n   = w_held;
        awready_n  = awready;
        wready_n   = wready;
        bvalid_n   = bvalid;
        bresp_n    = bresp;
        reg_we     = 1'b0;
        case (wr_state)
            W_IDLE: begin
                if (aw_held && w_held) begin
                    reg_we     = wr_ok;
                    bresp_n    = wr_ok ? RESP_OKAY : RESP_SLVERR;
                    bvalid_n   = 1'b1;
                    aw_held_n  = 1'b0;
                    w_held_n   = 1'b0;
                    awready_n  = 1'b0;
                    wready_n   = 1'b0;
                    wr_state_n = W_RESP;
                end else begin
                    if (aw_hs) aw_held_n = 1'b1;
                    if (w_hs)  w_held_n  = 1'b1;
                    awready_n = !(aw_held || aw_hs);
                    wready_n  = !(w_held || w_hs);
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_n   = 1'b0;
                    awready_n  = 1'b1;
                    wready_n   = 1'b1;
                    wr_state_n = W_IDLE;
                end
            end
            default: wr_state_n = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state <= W_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
        end else begin
            wr_state <= wr_state_n;
            aw_held  <= aw_held_n;
            w_held   <= w_held_n;
            awready  <= awready_n;
            wready   <= wready_n;
            bvalid   <= bvalid_n;
            bresp    <= bresp_n;
            if (aw_hs) awaddr_q <= awaddr;
            if (w_hs) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (reg_we) begin
            regs[wr_idx] <= apply_strb(regs[wr_idx], wdata_q, wstrb_q);
        end
    end

    // Read path: data is sampled from the bank on the AR edge, so a write committing
    // on that same edge is not yet visible.
    always_comb begin
        rd_state_n = rd_state;
        arready_n  = arready;
        rvalid_n   = rvalid;
        rresp_n    = rresp;
        rdata_n    = rdata;
        case (rd_state)
            R_IDLE: begin
                if (ar_hs) begin
                    rdata_n    = rd_ok ? regs[rd_idx] : '0;
                    rresp_n    = rd_ok ? RESP_OKAY : RESP_SLVERR;
                    rvalid_n   = 1'b1;
                    arready_n  = 1'b0;
                    rd_state_n = R_DATA;
                end else begin
                    arready_n = 1'b1;
                end
            end
            R_DATA: begin
                if (rready) begin
                    rvalid_n   = 1'b0;
                    arready_n  = 1'b1;
                    rd_state_n = R_IDLE;
                end
            end
            default: rd_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state <= R_IDLE;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rresp    <= RESP_OKAY;
            rdata    <= '0;
        end else begin
            rd_state <= rd_state_n;
            arready  <= arready_n;
            rvalid   <= rvalid_n;
            rresp    <= rresp_n;
            rdata    <= rdata_n;
        end
    end

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Scoreboard bench for axi4_lite_slave_regfile: directed scenarios plus randomized
// traffic against an array-based register model. Honours AXI4_LITE_REGFILE_PROT_EN.
module tb_axi4_lite_slave_regfile;

    localparam int          NUM_REGS = 16;
    localparam logic [31:0] BASE     = 32'h0000_0000;
    localparam logic [1:0]  OKAY     = 2'b00;
    localparam logic [1:0]  SLVERR   = 2'b10;

    logic        aclk, aresetn;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    axi4_lite_slave_regfile #(
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE),
        .ADDR_WIDTH(32)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    // ---------------- clock / reset ----------------
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // ---------------- scoreboard state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [1:0]  b_exp_q[$];
    logic [33:0] r_exp_q[$];
    logic [31:0] model_regs[NUM_REGS];
    bit          rand_rdy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event did not occur (t=%0t)", name, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic bit model_ok(input logic [31:0] addr, input logic [2:0] prot);
        longint a;
        bit     ok;
        a  = longint'(addr);
        ok = (a >= longint'(BASE)) && (a < longint'(BASE) + NUM_REGS * 4);
`ifdef AXI4_LITE_REGFILE_PROT_EN
        ok = ok && prot[0];
`else
        if (prot === 3'bxxx) ok = 1'b0;
`endif
        return ok;
    endfunction

    function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb, input logic [2:0] prot);
        int idx;
        if (!model_ok(addr, prot)) return SLVERR;
        idx = int'((addr - BASE) / 4);
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) model_regs[idx][8*b +: 8] = data[8*b +: 8];
        end
        return OKAY;
    endfunction

    function automatic logic [33:0] model_read(input logic [31:0] addr, input logic [2:0] prot);
        if (!model_ok(addr, prot)) return {SLVERR, 32'h0};
        return {OKAY, model_regs[int'((addr - BASE) / 4)]};
    endfunction

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge aclk);
            if (aresetn && bvalid && bready) begin
                if (b_exp_q.size() == 0) fail_now("b_unexpected");
                else check("bresp", 64'(bresp), 64'(b_exp_q.pop_front()));
            end
            if (aresetn && rvalid && rready) begin
                if (r_exp_q.size() == 0) fail_now("r_unexpected");
                else check("rresp_rdata", 64'({rresp, rdata}), 64'(r_exp_q.pop_front()));
            end
        end
    end

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            if (rand_rdy) begin
                bready = ($urandom_range(0, 3) != 0);
                rready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_aw(input logic [31:0] addr, input logic [2:0] prot, input int dly);
        bit got = 1'b0;
        repeat (dly) begin @(posedge aclk); #1; end
        awaddr = addr; awprot = prot; awvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (awready) begin got = 1'b1; break; end
        end
        if (!got) fail_now("aw_timeout");
        @(posedge aclk); #1;
        awvalid = 1'b0;
    endtask

    task automatic drive_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
        bit got = 1'b0;
        repeat (dly) begin @(posedge aclk); #1; end
        wdata = data; wstrb = strb; wvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (wready) begin got = 1'b1; break; end
        end
        if (!got) fail_now("w_timeout");
        @(posedge aclk); #1;
        wvalid = 1'b0;
    endtask

    task automatic drive_ar(input logic [31:0] addr, input logic [2:0] prot);
        bit got = 1'b0;
        araddr = addr; arprot = prot; arvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (arready) begin got = 1'b1; break; end
        end
        if (!got) fail_now("ar_timeout");
        @(posedge aclk); #1;
        arvalid = 1'b0;
    endtask

    task automatic wait_b();
        bit got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge aclk);
            if (bvalid && bready) begin got = 1'b1; break; end
        end
        if (!got) fail_now("b_timeout");
        @(posedge aclk); #1;
    endtask

    task automatic wait_r();
        bit got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge aclk);
            if (rvalid && rready) begin got = 1'b1; break; end
        end
        if (!got) fail_now("r_timeout");
        @(posedge aclk); #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [2:0] prot, input int aw_dly, input int w_dly);
        b_exp_q.push_back(model_write(addr, data, strb, prot));
        fork
            drive_aw(addr, prot, aw_dly);
            drive_w(data, strb, w_dly);
        join
        wait_b();
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [2:0] prot);
        r_exp_q.push_back(model_read(addr, prot));
        drive_ar(addr, prot);
        wait_r();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] addr;
        aresetn = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0;
        bready = 1'b0; rready = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = '0;

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("reset_outputs", 64'({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata}), 64'h0);
        aresetn = 1'b1;
        #1;
        check("ready_before_edge", 64'({awready, wready, arready}), 64'h0);
        @(negedge aclk);
        check("ready_after_release", 64'({awready, wready, arready}), 64'h7);
        @(posedge aclk); #1;

        // Read of an untouched register after reset.
        bready = 1'b1; rready = 1'b1;
        do_read(32'h08, 3'b001);

        // AW and W in the same cycle: bvalid two edges after the handshake.
        b_exp_q.push_back(model_write(32'h04, 32'hDEAD_BEEF, 4'hF, 3'b001));
        awaddr = 32'h04; awprot = 3'b001; awvalid = 1'b1;
        wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge aclk);
        check("same_cycle_readies", 64'({awready, wready}), 64'h3);
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge aclk);
        check("bvalid_edge1", 64'({bvalid, awready, wready}), 64'h0);
        @(negedge aclk);
        check("bvalid_edge2", 64'(bvalid), 64'h1);
        @(posedge aclk); #1;
        @(negedge aclk);
        check("readies_after_b", 64'({awready, wready, bvalid}), 64'h6);
        @(posedge aclk); #1;
        do_read(32'h04, 3'b001);

        // W leads AW by three cycles; byte-lane 0 only.
        b_exp_q.push_back(model_write(32'h04, 32'h0000_00AA, 4'b0001, 3'b001));
        wdata = 32'h0000_00AA; wstrb = 4'b0001; wvalid = 1'b1;
        @(negedge aclk);
        check("w_first_ready", 64'(wready), 64'h1);
        @(posedge aclk); #1;
        wvalid = 1'b0;
        repeat (2) begin
            @(negedge aclk);
            check("aw_wait_readies", 64'({awready, wready}), 64'h2);
            @(posedge aclk); #1;
        end
        awaddr = 32'h04; awprot = 3'b001; awvalid = 1'b1;
        @(negedge aclk);
        check("aw_late_ready", 64'({awready, wready}), 64'h2);
        @(posedge aclk); #1;
        awvalid = 1'b0;
        wait_b();
        do_read(32'h04, 3'b001);

        // Range boundaries and empty strobe.
        do_write(32'h40, 32'h1234_5678, 4'hF, 3'b001, 0, 0);
        do_read(32'h40, 3'b001);
        do_write(32'h3C, 32'hCAFE_F00D, 4'hF, 3'b001, 1, 0);
        do_read(32'h3F, 3'b001);
        do_write(32'h08, 32'hFFFF_FFFF, 4'h0, 3'b001, 0, 2);
        do_read(32'h08, 3'b001);
        do_write(32'hFFFF_FFFC, 32'h0BAD_0BAD, 4'hF, 3'b001, 0, 0);

        // rready held low: response stays stable, arready low.
        rready = 1'b0;
        r_exp_q.push_back(model_read(32'h04, 3'b001));
        drive_ar(32'h04, 3'b001);
        repeat (5) begin
            @(negedge aclk);
            check("r_hold", 64'({rvalid, arready, rresp, rdata}), 64'({1'b1, 1'b0, OKAY, model_regs[1]}));
        end
        @(posedge aclk); #1;
        rready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
        @(negedge aclk);
        check("ar_reready", 64'({arready, rvalid}), 64'h2);
        @(posedge aclk); #1;
        rready = 1'b1;

`ifdef AXI4_LITE_REGFILE_PROT_EN
        do_write(32'h10, 32'h5555_AAAA, 4'hF, 3'b000, 0, 0);
        do_read(32'h10, 3'b001);
        do_read(32'h10, 3'b000);
        do_write(32'h10, 32'h5555_AAAA, 4'hF, 3'b001, 0, 0);
        do_read(32'h10, 3'b001);
`endif

        // Randomized traffic.
        rand_rdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) addr = $urandom;
            else addr = BASE + 32'($urandom_range(0, NUM_REGS + 3) * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0)
                do_write(addr, $urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                         $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_read(addr, 3'($urandom_range(0, 7)));
        end
        rand_rdy = 1'b0;
        #2;
        bready = 1'b1; rready = 1'b1;

        // Reset in the middle of a write: no response, bank cleared.
        @(posedge aclk); #1;
        awaddr = 32'h00; awprot = 3'b001; awvalid = 1'b1;
        wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        aresetn = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = '0;
        @(negedge aclk);
        check("midreset_outputs", 64'({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata}), 64'h0);
        aresetn = 1'b1;
        repeat (3) begin
            @(negedge aclk);
            check("midreset_no_b", 64'(bvalid), 64'h0);
        end
        @(posedge aclk); #1;
        do_read(32'h00, 3'b001);
        do_read(32'h04, 3'b001);

        repeat (3) @(posedge aclk);
        check("b_queue_drained", 64'(b_exp_q.size()), 64'h0);
        check("r_queue_drained", 64'(r_exp_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

endmodule

// File: doc/axi4_lite_slave_regfile.md
Name: axi4_lite_slave_regfile

Overview:
- AXI4-Lite responder (slave end) holding a bank of 32-bit memory-mapped registers.
- Accepts write-address and write-data independently, commits the write with byte strobes, and returns a write response.
- Serves reads with a single-beat response.
- Sits behind the AXI4-Lite master adaptor as a real endpoint, replacing the pass-through slave adaptor in register-bank subsystems.

Parameters:
- NUM_REGS, 16: number of 32-bit registers; power of two, 2..256.
- BASE_ADDR, 32'h0000_0000: byte base address of the bank; aligned to NUM_REGS*4.
- ADDR_WIDTH, 32: width of awaddr/araddr.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- awaddr  in  ADDR_WIDTH  write address.
- awprot  in  3  write protection.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  32  write data.
- wstrb  in  4  byte strobes; bit n enables wdata[8n+7:8n].
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response (2'b00 OKAY, 2'b10 SLVERR).
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- araddr  in  ADDR_WIDTH  read address.
- arprot  in  3  read protection.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  32  read data.
- rresp  out  2  read response.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.

Behaviour:
- Reset (aresetn=0, async):
  - awready, wready, arready, bvalid, rvalid = 0; bresp, rresp = 2'b00; rdata = 0.
  - All registers = 0; both FSMs go to IDLE.
  - All outputs are registered.
- Readies rise on the first aclk edge after reset release.
- Write FSM states: W_IDLE, W_RESP.
  - In W_IDLE, awready=1 until AW is captured and wready=1 until W is captured; each drops the cycle after its own handshake.
  - AW and W may arrive in either order or in the same cycle.
  - Once both are held, the commit happens on the next edge: the register is updated per wstrb, bresp is set, bvalid=1, and the FSM moves to W_RESP.
  - Latency when AW and W arrive in the same cycle: bvalid asserts 2 edges after the handshake.
  - In W_RESP, bvalid is held until bvalid&&bready. Then bvalid=0, return to W_IDLE, and the readies re-assert on that same edge.
  - awready and wready are 0 throughout W_RESP.
- Read FSM states: R_IDLE, R_DATA.
  - In R_IDLE, arready=1. On arvalid&&arready: capture rdata/rresp on that edge, set arready=0 and rvalid=1, move to R_DATA.
  - In R_DATA, rvalid and rdata are held stable until rready. Then rvalid=0, arready=1, return to R_IDLE.
- Address decode:
  - index = (addr - BASE_ADDR) >> 2; addr[1:0] are ignored.
  - Any address outside [BASE_ADDR, BASE_ADDR + NUM_REGS*4) gives SLVERR. An out-of-range write changes no register; an out-of-range read returns rdata=0.
- wstrb=4'b0000 with a valid address: no register change, bresp OKAY.
- Write commit and read capture on the same edge to the same register: the read returns the pre-write value.
- The read and write paths are fully independent; there is no arbitration stall.
- awprot and arprot are ignored unless the optional feature below is compiled in.
- If reset asserts mid-transaction, the in-flight transaction is discarded and no response is issued.

Optional Feature:
- Macro: AXI4_LITE_REGFILE_PROT_EN.
- Defined: an access with prot[0]=0 (unprivileged) returns SLVERR. A rejected write changes no register; a rejected read returns rdata=0.
- Undefined: prot is unused and the protection check logic is absent.

Decomposition:
- Shared package holds:
  - Response codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - Write FSM state encoding and read FSM state encoding.
  - Constant DATA_WIDTH=32.
- One sub-module, axi4_lite_addr_decode: combinational in-range check plus index computation, instantiated once for writes and once for reads.

Test Plan:
- Reset release → awready=wready=arready=1 on the first edge; a read of 0x08 returns rdata=0, rresp OKAY.
- AW 0x04 and W 0xDEADBEEF (wstrb 4'hF) in the same cycle, bready=1 → bvalid 2 edges later, bresp 00; a read of 0x04 returns 0xDEADBEEF.
- W 0x000000AA with wstrb 4'b0001 issued 3 cycles before AW 0x04 → register becomes 0xDEADBEAA; awready stays 1 while wready=0 until AW arrives.
- Write to 0x40 with NUM_REGS=16 → bresp 2'b10, no register changes; a read of 0x40 returns rresp 2'b10, rdata=0.
- Read 0x04 with rready held low for 5 cycles → rvalid and rdata stay stable, arready=0; arready returns to 1 after the rready handshake.
- With AXI4_LITE_REGFILE_PROT_EN, a write with awprot=3'b000 → bresp SLVERR and the register is unchanged; the same write with awprot=3'b001 → OKAY.
